apb_master_gen: RTL and testbench
=================================

Name: apb_master_gen

Overview:
- Parametrised APB4 master and successor to the fixed 32-bit read/write master.
- Accepts transfer commands on a valid/ready request interface and drives a single APB slave through SETUP/ACCESS phases.
- Returns read data plus error and timeout status on a one-cycle response strobe.
- Adds byte strobes, PSLVERR capture, a wait-state timeout watchdog and back-to-back transfers with no IDLE bubble.

Parameters:
- ADDR_W, 32: address width of cmd_addr_i and paddr_o.
- DATA_W, 32: data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 16: maximum consecutive ACCESS cycles with pready_i low before abort. 0 disables the watchdog.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_W  transfer address.
- cmd_wdata_i  in  DATA_W  write data.
- cmd_strb_i  in  DATA_W/8  write byte strobes.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- paddr_o  out  ADDR_W  APB address.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_W  APB write data.
- pstrb_o  out  DATA_W/8  APB byte strobes.
- pready_i  in  1  slave ready.
- prdata_i  in  DATA_W  slave read data.
- pslverr_i  in  1  slave error.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  DATA_W  captured read data; 0 for writes and timeouts.
- rsp_err_o  out  1  pslverr_i sampled at completion, or timeout.
- rsp_timeout_o  out  1  transfer aborted by the watchdog.

Behaviour:
- Reset values: FSM in IDLE. psel_o, penable_o, pwrite_o and rsp_* are 0; paddr_o, pwdata_o, pstrb_o are 0; timeout counter is 0.
- Reset asserted mid-transfer aborts immediately: bus signals return to 0 the next cycle and no response is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready_o = 1.
  - On accept, register addr, write, wdata and strb into the paddr_o/pwrite_o/pwdata_o/pstrb_o registers; next state SETUP.
  - For reads, pstrb_o and pwdata_o are registered as 0.
- SETUP: psel_o = 1, penable_o = 0; always lasts exactly one cycle; next state ACCESS.
- ACCESS, normal completion:
  - psel_o = 1, penable_o = 1; bus outputs are held stable.
  - Completion when pready_i = 1. The next cycle has rsp_valid_o = 1 with rsp_err_o = pslverr_i and rsp_timeout_o = 0.
  - rsp_rdata_o = prdata_i for reads, 0 for writes; both are sampled at the completion edge.
- ACCESS, back-to-back:
  - cmd_ready_o = pready_i (combinational) in ACCESS; 0 in SETUP.
  - If a command is accepted in the completion cycle, the new command is registered and the next state is SETUP. psel_o stays 1 and penable_o drops to 0, with no IDLE cycle.
  - Otherwise the next state is IDLE and psel_o/penable_o go to 0.
- Watchdog (TIMEOUT_CYCLES > 0):
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i = 0.
  - When the counter reaches TIMEOUT_CYCLES, the transfer is aborted in that cycle. The next cycle has rsp_valid_o = 1, rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0, and the FSM goes to IDLE.
  - cmd_ready_o = 0 in the abort cycle, so no back-to-back transfer follows a timeout.
  - pready_i arriving in the same cycle as the terminal count wins: normal completion.
- Latency, zero wait states: accept at edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid_o in N+3. Each wait state adds 1 cycle.
- rsp_valid_o is a single-cycle pulse per transfer with no backpressure; downstream must sample it.
- Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- pslverr_i is ignored except in the completion cycle.

Test Plan:
- Reset, then read addr 0x10, slave drives pready_i = 1 in the first ACCESS cycle with prdata_i = 0xDEADBEEF -> psel_o 1 cycle before penable_o; rsp_valid_o 3 cycles after accept with rsp_rdata_o = 0xDEADBEEF, rsp_err_o = 0; pstrb_o = 0 throughout.
- Write addr 0x20, wdata 0x12345678, strb 0x3, 2 wait states -> ACCESS lasts 3 cycles with paddr_o/pwdata_o/pstrb_o stable; rsp_valid_o with rsp_rdata_o = 0, rsp_err_o = 0.
- Two commands (write 0x30, then read 0x34) presented with cmd_valid_i held high -> second is accepted in the first completion cycle; psel_o stays 1 continuously; penable_o pattern is 0,1,0,1; two rsp_valid_o pulses.
- Read with pslverr_i = 1 at completion -> rsp_err_o = 1, rsp_timeout_o = 0. A pslverr_i pulse during earlier wait cycles produces no error.
- TIMEOUT_CYCLES = 4, pready_i held 0 -> abort after 4 ACCESS cycles; rsp_valid_o with err = 1, timeout = 1, rdata = 0; FSM returns to IDLE; a following read completes normally. Repeat with pready_i = 1 exactly on the 4th cycle -> normal completion, timeout = 0.
- Reset asserted during ACCESS -> all outputs 0 at the next edge, no rsp_valid_o pulse; cmd_ready_o = 1 after reset deasserts.

Source files
------------

// File: rtl/apb_master_gen.sv
// apb_master_gen: parametrised APB4 master with byte strobes,
// PSLVERR capture, wait-state watchdog and back-to-back transfers.
module apb_master_gen #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_strb_i,
    output logic                psel_o,
    output logic                penable_o,
    output logic [ADDR_W-1:0]   paddr_o,
    output logic                pwrite_o,
    output logic [DATA_W-1:0]   pwdata_o,
    output logic [DATA_W/8-1:0] pstrb_o,
    input  logic                pready_i,
    input  logic [DATA_W-1:0]   prdata_i,
    input  logic                pslverr_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = TMO_EN ? CNT_W'(TIMEOUT_CYCLES) : '0;
    localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_paddr;
    logic               r_pwrite;
    logic [DATA_W-1:0]  r_pwdata;
    logic [STRB_W-1:0]  r_pstrb;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_rsp_timeout;
    logic               w_ready;
    logic               w_accept;
    logic               w_done;
    logic               w_abort;
    logic               w_tmo_hit;

    // Terminal count: this wait cycle would bring the counter to the limit.
    assign w_tmo_hit = TMO_EN && (r_cnt == CNT_LAST);
    assign w_accept  = cmd_valid_i && w_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, command ready and completion/abort decode.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (cmd_valid_i) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready_i) begin
                    w_done  = 1'b1;
                    w_ready = 1'b1;
                    w_next  = cmd_valid_i ? S_SETUP : S_IDLE;
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Wait-state watchdog: cleared entering ACCESS, saturating count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS && !pready_i && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Bus registers load on accept; reads carry zero data and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_accept) begin
            r_paddr  <= cmd_addr_i;
            r_pwrite <= cmd_write_i;
            r_pwdata <= cmd_write_i ? cmd_wdata_i : '0;
            r_pstrb  <= cmd_write_i ? cmd_strb_i : '0;
        end
    end

    // One-cycle response strobe after completion or watchdog abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= w_done || w_abort;
            r_rsp_rdata   <= (w_done && !r_pwrite) ? prdata_i : '0;
            r_rsp_err     <= w_abort || (w_done && pslverr_i);
            r_rsp_timeout <= w_abort;
        end
    end

    assign cmd_ready_o   = w_ready;
    assign psel_o        = (r_state != S_IDLE);
    assign penable_o     = (r_state == S_ACCESS);
    assign paddr_o       = r_paddr;
    assign pwrite_o      = r_pwrite;
    assign pwdata_o      = r_pwdata;
    assign pstrb_o       = r_pstrb;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_gen.sv
// tb_apb_master_gen: randomized APB master bench with a reactive
// slave model, response scoreboard and a mid-transfer reset case.
module tb_apb_master_gen;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int T      = 4;
    localparam int N_CMDS = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic [SW-1:0] cmd_strb_i;
    logic          psel_o;
    logic          penable_o;
    logic [AW-1:0] paddr_o;
    logic          pwrite_o;
    logic [DW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic          pready_i;
    logic [DW-1:0] prdata_i;
    logic          pslverr_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;

    apb_master_gen #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i),
        .cmd_strb_i(cmd_strb_i),
        .psel_o(psel_o),
        .penable_o(penable_o),
        .paddr_o(paddr_o),
        .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o),
        .pstrb_o(pstrb_o),
        .pready_i(pready_i),
        .prdata_i(prdata_i),
        .pslverr_i(pslverr_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
        int            at;
    } rsp_t;

    cmd_t issued[$];
    rsp_t exp_q[$];
    cmd_t dir_q[$];
    int   force_w[$];
    logic force_e[$];
    logic [DW-1:0] force_d[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_issued = 0;
    bit   acc_last = 0;
    cmd_t cur;
    cmd_t scmd;
    int   sw;
    int   scnt;
    logic serr;
    logic [DW-1:0] srd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [SW-1:0] s);
        cmd_t c;
        c.wr = wr;
        c.addr = a;
        c.wdata = d;
        c.strb = s;
        return c;
    endfunction

    // Slave model: picks wait count / error / data at SETUP and
    // predicts the response from the transfer rules.
    task automatic step_slave();
        rsp_t r;
        if (psel_o && !penable_o) begin
            if (issued.size() == 0) begin
                chk("setup_without_cmd", 1, 0);
            end else begin
                scmd = issued.pop_front();
                chk("setup_addr", paddr_o, scmd.addr);
                chk("setup_write", pwrite_o, scmd.wr);
                chk("setup_wdata", pwdata_o, scmd.wr ? scmd.wdata : '0);
                chk("setup_strb", pstrb_o, scmd.wr ? scmd.strb : '0);
                sw = force_w.size() ? force_w.pop_front() : int'($urandom_range(0, 6));
                serr = force_e.size() ? force_e.pop_front() : ($urandom % 4 == 0);
                srd = force_d.size() ? force_d.pop_front() : $urandom;
                scnt = 0;
                r.to = (sw >= T);
                r.err = r.to ? 1'b1 : serr;
                r.rdata = (r.to || scmd.wr) ? '0 : srd;
                r.at = r.to ? cyc + T + 1 : cyc + sw + 2;
                exp_q.push_back(r);
            end
            pready_i = 1'b0;
            pslverr_i = $urandom % 2;
        end else if (psel_o && penable_o) begin
            chk("access_stable", {paddr_o, pwdata_o, pstrb_o, pwrite_o},
                {scmd.addr, scmd.wr ? scmd.wdata : 32'h0,
                 scmd.wr ? scmd.strb : 4'h0, scmd.wr});
            if (scnt == sw) begin
                pready_i = 1'b1;
                prdata_i = srd;
                pslverr_i = serr;
            end else begin
                pready_i = 1'b0;
                prdata_i = $urandom;
                pslverr_i = $urandom % 2;
            end
            scnt++;
        end else begin
            pready_i = 1'b0;
            pslverr_i = 1'b0;
        end
    endtask

    // Command source: holds a command until accepted.
    task automatic step_master();
        if (acc_last || !cmd_valid_i) begin
            if (dir_q.size() > 0) begin
                cur = dir_q.pop_front();
                cmd_valid_i = 1'b1;
            end else if (n_issued < N_CMDS && $urandom % 4 != 0) begin
                cur = mk($urandom % 2, $urandom & 32'hFFFF_FFFC, $urandom, $urandom % 16);
                cmd_valid_i = 1'b1;
            end else begin
                cmd_valid_i = 1'b0;
            end
        end
        cmd_write_i = cur.wr;
        cmd_addr_i  = cur.addr;
        cmd_wdata_i = cur.wdata;
        cmd_strb_i  = cur.strb;
        #1;
        acc_last = cmd_valid_i && cmd_ready_o;
        if (acc_last) begin
            issued.push_back(cur);
            n_issued++;
        end
    endtask

    // Response monitor: every strobe must match the oldest prediction.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_err", rsp_err_o, e.err);
                chk("rsp_timeout", rsp_timeout_o, e.to);
                chk("rsp_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        bit done;
        reset = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i = '0;
        cmd_wdata_i = '0;
        cmd_strb_i = '0;
        pready_i = 1'b0;
        prdata_i = '0;
        pslverr_i = 1'b0;
        cur = mk(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_bus", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o}, '0);
        chk("reset_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o}, '0);
        chk("reset_ready", cmd_ready_o, 1);
        reset = 1'b0;

        dir_q.push_back(mk(0, 32'h10, 0, 0));
        dir_q.push_back(mk(1, 32'h20, 32'h12345678, 4'h3));
        dir_q.push_back(mk(1, 32'h30, 32'hA5A5_0001, 4'hF));
        dir_q.push_back(mk(0, 32'h34, 0, 0));
        dir_q.push_back(mk(0, 32'h40, 0, 0));
        dir_q.push_back(mk(0, 32'h44, 0, 0));
        dir_q.push_back(mk(0, 32'h48, 0, 0));
        dir_q.push_back(mk(0, 32'h4C, 0, 0));
        force_w = '{0, 2, 0, 0, 2, 9, 3, 4};
        force_e = '{0, 0, 0, 0, 1, 0, 0, 0};
        force_d = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h1111_2222,
                    32'h3333_4444, 32'h0, 32'h5555_6666, 32'h0};

        done = 0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            step_slave();
            step_master();
            done = (n_issued >= N_CMDS) && !cmd_valid_i && issued.size() == 0
                   && exp_q.size() == 0 && !psel_o;
        end
        chk("drain_done", done, 1);

        dir_q.push_back(mk(0, 32'h80, 0, 0));
        force_w.push_back(20);
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            step_slave();
            if (psel_o && penable_o) begin
                done = 1;
            end else begin
                step_master();
            end
        end
        chk("reached_access", done, 1);
        reset = 1'b1;
        cmd_valid_i = 1'b0;
        pready_i = 1'b0;
        exp_q.delete();
        issued.delete();
        acc_last = 0;
        @(negedge clk);
        chk("midreset_bus", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o}, '0);
        chk("midreset_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o}, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", cmd_ready_o, 1);
        repeat (8) begin
            @(negedge clk);
            chk("post_reset_idle", {psel_o, rsp_valid_o}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
